vga_rd_scheduler: RTL and testbench
===================================

VGA_RD_SCHEDULER -- requirements
Module: vga_rd_scheduler

Interface
REQ-001 SHALL have parameter BASE_ADDR0, default 28'h000_0000, meaning the DDR byte address of frame bank 0.
REQ-002 SHALL have parameter BASE_ADDR1, default 28'h010_0000, meaning the DDR byte address of frame bank 1.
REQ-003 SHALL have parameter FRAME_BYTES, default 983040, meaning the bytes per frame (1280x768, 8 bit per pixel).
REQ-004 SHALL have parameter BURST_LEN, default 256, meaning the bytes per read burst; FRAME_BYTES is an exact multiple of BURST_LEN.
REQ-005 SHALL have parameter FIFO_DEPTH, default 2048, meaning the display FIFO depth in bytes.
REQ-006 SHALL have port vga_clk, input, 1 bit: the only clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous reset, active high.
REQ-008 SHALL have port frame_start, input, 1 bit: one-cycle pulse marking a new display frame (falling edge of VS).
REQ-009 SHALL have port fifo_wcnt, input, 12 bits: current display FIFO fill level in bytes.
REQ-010 SHALL have port rd_req, output, 1 bit: DDR read burst request.
REQ-011 SHALL have port rd_addr, output, 28 bits: burst start byte address.
REQ-012 SHALL have port rd_len, output, 10 bits: burst length, constant BURST_LEN.
REQ-013 SHALL have port rd_ack, input, 1 bit: DDR controller accepted the request.
REQ-014 SHALL have port rd_data_done, input, 1 bit: one-cycle pulse after the last beat of the accepted burst has been written to the FIFO.
REQ-015 SHALL have port wr_frame_done, input, 1 bit: pulse from the write side when a complete new frame is stored in the non-displayed bank.
REQ-016 SHALL have port fifo_flush, output, 1 bit: one-cycle display FIFO clear.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse when all frame bursts have completed.
REQ-018 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-019 SHALL implement the states IDLE, FLUSH, CHECK, REQ and WAIT_DONE, with a byte-offset counter off of width 20 bits or more.
REQ-020 In IDLE, frame_start SHALL cause a transition to FLUSH.
REQ-021 In FLUSH, the block SHALL assert fifo_flush for exactly one cycle, set off to 0 and go to CHECK.
REQ-022 In CHECK, when off equals FRAME_BYTES, the block SHALL pulse frame_done and go to IDLE.
REQ-023 In CHECK, when off is less than FRAME_BYTES and fifo_wcnt is at most FIFO_DEPTH-BURST_LEN, the block SHALL go to REQ; otherwise it SHALL stay in CHECK.
REQ-024 In REQ, rd_req SHALL be 1 and rd_addr SHALL equal base+off, both held stable until rd_ack; on rd_ack the block SHALL go to WAIT_DONE, and rd_req SHALL be 0 in the following cycle.
REQ-025 In WAIT_DONE, rd_data_done SHALL add BURST_LEN to off and cause a transition to CHECK.
REQ-026 frame_start in CHECK SHALL cause an immediate transition to FLUSH.
REQ-027 frame_start in REQ or WAIT_DONE SHALL set a pending flag; an outstanding request or burst is never abandoned.
REQ-028 When the pending flag is set, the rd_data_done that completes the burst SHALL cause a transition to FLUSH instead of CHECK and SHALL clear the flag.
REQ-029 frame_start and rd_ack in the same cycle in REQ SHALL cause the ack to be taken and the pending flag to be set.
REQ-030 frame_start and rd_data_done in the same cycle SHALL cause a transition to FLUSH.
REQ-031 rd_data_done or rd_ack outside the states that expect it SHALL be ignored.
REQ-032 rd_addr SHALL be computed modulo 2^28.

Reset
REQ-033 While rst=1, the block SHALL hold state IDLE, off=0, pending=0 and bank=0, with rd_req, fifo_flush, frame_done and busy at 0 and rd_addr at 0.
REQ-034 rst asserted mid-burst SHALL abort immediately; after release the block SHALL wait for the next frame_start.

Configuration
REQ-035 With macro VGA_RD_PINGPONG_EN defined, wr_frame_done SHALL set a ready flag.
REQ-036 With VGA_RD_PINGPONG_EN defined, in FLUSH with ready=1 the block SHALL toggle bank and clear ready; base SHALL be BASE_ADDR1 when bank=1, else BASE_ADDR0.
REQ-037 With VGA_RD_PINGPONG_EN defined, wr_frame_done coinciding with FLUSH SHALL take effect at the next FLUSH.
REQ-038 Without VGA_RD_PINGPONG_EN, base SHALL always be BASE_ADDR0 and wr_frame_done SHALL be ignored.

Verification
REQ-039 With fifo_wcnt=0 and rd_ack and rd_data_done returned immediately after frame_start, the bench SHALL see 3840 bursts at addresses 0x0000000 through 0x00EFF00 in steps of 0x100, then one frame_done pulse.
REQ-040 With fifo_wcnt=1900 in CHECK, the bench SHALL see rd_req stay 0; after fifo_wcnt drops to 1792, rd_req SHALL be 1 on the next cycle.
REQ-041 With rd_ack withheld for 50 cycles, the bench SHALL see rd_req and rd_addr stable for all 50 cycles.
REQ-042 frame_start during WAIT_DONE at off=0x4000 SHALL produce no new rd_req before rd_data_done, then a fifo_flush pulse, then the next rd_addr equal to base+0.
REQ-043 With VGA_RD_PINGPONG_EN defined, wr_frame_done followed by frame_start SHALL give a first rd_addr of 0x0100000; a second frame_start without wr_frame_done SHALL keep base at 0x0100000.
REQ-044 rst asserted while rd_req=1 SHALL drive rd_req to 0 asynchronously, and the block SHALL stay in IDLE until frame_start.

Source files
------------

// File: rtl/vga_rd_scheduler.sv
// Issues DDR read bursts that refill the VGA display FIFO, walking one frame per frame_start.
// Optional write/read bank ping-pong is enabled with `define VGA_RD_PINGPONG_EN.
module vga_rd_scheduler #(
    parameter logic [27:0] BASE_ADDR0  = 28'h000_0000,
    parameter logic [27:0] BASE_ADDR1  = 28'h010_0000,
    parameter int unsigned FRAME_BYTES = 983040,
    parameter int unsigned BURST_LEN   = 256,
    parameter int unsigned FIFO_DEPTH  = 2048
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        frame_start,
    input  logic [11:0] fifo_wcnt,
    output logic        rd_req,
    output logic [27:0] rd_addr,
    output logic [9:0]  rd_len,
    input  logic        rd_ack,
    input  logic        rd_data_done,
    input  logic        wr_frame_done,
    output logic        fifo_flush,
    output logic        frame_done,
    output logic        busy
);

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned OFF_W  = 28;
    localparam int unsigned WCNT_W = 12;
    localparam int unsigned LEN_W  = 10;

    localparam logic [OFF_W-1:0]  FRAME_END  = OFF_W'(FRAME_BYTES);
    localparam logic [OFF_W-1:0]  BURST_STEP = OFF_W'(BURST_LEN);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(FIFO_DEPTH - BURST_LEN);

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        CHECK,
        REQ,
        WAIT_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [OFF_W-1:0]    off, off_nxt;
    logic                pending, pending_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic                frame_done_nxt;
    logic [ADDR_W-1:0]   base;

    assign rd_len = LEN_W'(BURST_LEN);

`ifdef VGA_RD_PINGPONG_EN
    logic bank, bank_nxt;
    logic ready, ready_nxt;

    // A stored write frame is picked up only at a FLUSH; a notice arriving during FLUSH waits for the next one
    always_comb begin
        bank_nxt  = bank;
        ready_nxt = ready;
        if (state == FLUSH && ready) begin
            bank_nxt  = ~bank;
            ready_nxt = 1'b0;
        end
        if (wr_frame_done) begin
            ready_nxt = 1'b1;
        end
    end

    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            bank  <= 1'b0;
            ready <= 1'b0;
        end else begin
            bank  <= bank_nxt;
            ready <= ready_nxt;
        end
    end
`else
    logic bank;
    logic unused_wr_frame_done;

    assign bank                 = 1'b0;
    assign unused_wr_frame_done = wr_frame_done;
`endif

    assign base = bank ? BASE_ADDR1 : BASE_ADDR0;

    // Next-state and next-value logic; outputs are registered from the next state
    always_comb begin
        state_nxt      = state;
        off_nxt        = off;
        pending_nxt    = pending;
        addr_nxt       = rd_addr;
        frame_done_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                off_nxt     = '0;
                pending_nxt = 1'b0;
                state_nxt   = CHECK;
            end
            CHECK: begin
                if (frame_start) begin
                    state_nxt = FLUSH;
                end else if (off == FRAME_END) begin
                    frame_done_nxt = 1'b1;
                    state_nxt      = IDLE;
                end else if (off < FRAME_END && fifo_wcnt <= WCNT_LIMIT) begin
                    addr_nxt  = base + off;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (frame_start) begin
                    pending_nxt = 1'b1;
                end
                if (rd_ack) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rd_data_done) begin
                    off_nxt     = off + BURST_STEP;
                    pending_nxt = 1'b0;
                    state_nxt   = (pending || frame_start) ? FLUSH : CHECK;
                end else if (frame_start) begin
                    pending_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            off        <= '0;
            pending    <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
            fifo_flush <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            off        <= off_nxt;
            pending    <= pending_nxt;
            rd_req     <= (state_nxt == REQ);
            rd_addr    <= addr_nxt;
            fifo_flush <= (state_nxt == FLUSH);
            frame_done <= frame_done_nxt;
            busy       <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_vga_rd_scheduler.sv
// Self-checking bench for vga_rd_scheduler: threshold vector table, address scoreboard and corner sequences.
module tb_vga_rd_scheduler;

    localparam int unsigned NBURST = 983040 / 256;
`ifdef VGA_RD_PINGPONG_EN
    localparam logic [27:0] PP_BASE = 28'h010_0000;
`else
    localparam logic [27:0] PP_BASE = 28'h000_0000;
`endif

    logic        vga_clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [11:0] fifo_wcnt;
    logic        rd_req;
    logic [27:0] rd_addr;
    logic [9:0]  rd_len;
    logic        rd_ack;
    logic        rd_data_done;
    logic        wr_frame_done;
    logic        fifo_flush;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [27:0] exp_q[$];

    typedef struct {
        logic [11:0] wcnt;
        logic        exp_req;
    } vec_t;
    vec_t vecs[8];

    vga_rd_scheduler dut (
        .vga_clk      (vga_clk),
        .rst          (rst),
        .frame_start  (frame_start),
        .fifo_wcnt    (fifo_wcnt),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_len       (rd_len),
        .rd_ack       (rd_ack),
        .rd_data_done (rd_data_done),
        .wr_frame_done(wr_frame_done),
        .fifo_flush   (fifo_flush),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        frame_start   = 1'b0;
        rd_ack        = 1'b0;
        rd_data_done  = 1'b0;
        wr_frame_done = 1'b0;
        fifo_wcnt     = 12'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        exp_q.delete();
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int w = 0;
        while (rd_req !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        ok = (rd_req === 1'b1);
        if (!ok) chk("req_timeout", 32'(rd_req), 32'd1);
    endtask

    function automatic logic [27:0] pop_exp();
        if (exp_q.size() == 0) return 28'hFFF_FFFF;
        return exp_q.pop_front();
    endfunction

    task automatic serve_burst();
        bit ok;
        logic [27:0] e;
        wait_req(ok);
        if (!ok) return;
        e = pop_exp();
        chk("rd_addr", 32'(rd_addr), 32'(e));
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("req_drop_after_ack", 32'(rd_req), 32'd0);
        rd_data_done = 1'b1;
        tick();
        rd_data_done = 1'b0;
    endtask

    initial begin
        bit ok;
        int bad;
        int w;

        vecs[0] = '{12'd0,    1'b1};
        vecs[1] = '{12'd1024, 1'b1};
        vecs[2] = '{12'd1791, 1'b1};
        vecs[3] = '{12'd1792, 1'b1};
        vecs[4] = '{12'd1793, 1'b0};
        vecs[5] = '{12'd1900, 1'b0};
        vecs[6] = '{12'd2048, 1'b0};
        vecs[7] = '{12'd4095, 1'b0};

        // Reset values while rst is held
        rst           = 1'b1;
        frame_start   = 1'b0;
        rd_ack        = 1'b0;
        rd_data_done  = 1'b0;
        wr_frame_done = 1'b0;
        fifo_wcnt     = 12'd0;
        tick();
        tick();
        chk("rst_rd_req", 32'(rd_req), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_fifo_flush", 32'(fifo_flush), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rd_len", 32'(rd_len), 32'd256);
        rst = 1'b0;
        tick();

        // Stray ack/done in IDLE are ignored
        rd_ack       = 1'b1;
        rd_data_done = 1'b1;
        tick();
        rd_ack       = 1'b0;
        rd_data_done = 1'b0;
        tick();
        chk("idle_stray_busy", 32'(busy), 32'd0);
        chk("idle_stray_req", 32'(rd_req), 32'd0);

        // Full frame with immediate ack/done
        pulse_frame();
        chk("flush_pulse", 32'(fifo_flush), 32'd1);
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < int'(NBURST); i++) exp_q.push_back(28'(i * 256));
        tick();
        chk("flush_single", 32'(fifo_flush), 32'd0);
        for (int i = 0; i < int'(NBURST); i++) serve_burst();
        w = 0;
        while (frame_done !== 1'b1 && w < 5) begin
            tick();
            w++;
        end
        chk("frame_done_pulse", 32'(frame_done), 32'd1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        tick();
        chk("frame_done_single", 32'(frame_done), 32'd0);
        chk("idle_after_frame", 32'(busy), 32'd0);
        chk("no_req_after_frame", 32'(rd_req), 32'd0);

        // FIFO threshold vector table
        foreach (vecs[k]) begin
            do_reset();
            fifo_wcnt = vecs[k].wcnt;
            pulse_frame();
            repeat (4) tick();
            chk($sformatf("thr_req_%0d", vecs[k].wcnt), 32'(rd_req), 32'(vecs[k].exp_req));
            if (vecs[k].exp_req) chk("thr_addr", 32'(rd_addr), 32'd0);
        end

        // Gated in CHECK, then release at the boundary
        do_reset();
        fifo_wcnt = 12'd1900;
        pulse_frame();
        bad = 0;
        repeat (6) begin
            tick();
            if (rd_req !== 1'b0) bad++;
        end
        chk("gated_req_cycles", 32'(bad), 32'd0);
        fifo_wcnt = 12'd1792;
        tick();
        chk("release_req", 32'(rd_req), 32'd1);

        // Withheld ack: request stays stable
        bad = 0;
        repeat (50) begin
            tick();
            if (rd_req !== 1'b1 || rd_addr !== 28'h0) bad++;
        end
        chk("hold_unstable_cycles", 32'(bad), 32'd0);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("hold_req_drop", 32'(rd_req), 32'd0);
        fifo_wcnt    = 12'd2000;
        rd_data_done = 1'b1;
        tick();
        rd_data_done = 1'b0;
        tick();
        chk("check_held", 32'(rd_req), 32'd0);

        // frame_start in CHECK flushes at once
        pulse_frame();
        chk("check_start_flush", 32'(fifo_flush), 32'd1);

        // frame_start during WAIT_DONE at off 0x4000
        do_reset();
        pulse_frame();
        for (int i = 0; i <= 64; i++) exp_q.push_back(28'(i * 256));
        for (int i = 0; i < 64; i++) serve_burst();
        wait_req(ok);
        chk("wait_start_addr", 32'(rd_addr), 32'(pop_exp()));
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        pulse_frame();
        bad = 0;
        repeat (5) begin
            tick();
            if (rd_req !== 1'b0 || fifo_flush !== 1'b0) bad++;
        end
        chk("pending_quiet_cycles", 32'(bad), 32'd0);
        rd_data_done = 1'b1;
        tick();
        rd_data_done = 1'b0;
        chk("pending_flush", 32'(fifo_flush), 32'd1);
        tick();
        chk("pending_flush_single", 32'(fifo_flush), 32'd0);
        exp_q.push_back(PP_BASE - PP_BASE);
        serve_burst();

        // frame_start together with rd_ack in REQ
        wait_req(ok);
        chk("ack_start_addr", 32'(rd_addr), 32'h100);
        rd_ack      = 1'b1;
        frame_start = 1'b1;
        tick();
        rd_ack      = 1'b0;
        frame_start = 1'b0;
        chk("ack_start_taken", 32'(rd_req), 32'd0);
        chk("ack_start_no_flush", 32'(fifo_flush), 32'd0);
        rd_data_done = 1'b1;
        tick();
        rd_data_done = 1'b0;
        chk("ack_start_flush", 32'(fifo_flush), 32'd1);

        // frame_start together with rd_data_done
        wait_req(ok);
        chk("done_start_addr", 32'(rd_addr), 32'h0);
        rd_ack = 1'b1;
        tick();
        rd_ack       = 1'b0;
        rd_data_done = 1'b1;
        frame_start  = 1'b1;
        tick();
        rd_data_done = 1'b0;
        frame_start  = 1'b0;
        chk("done_start_flush", 32'(fifo_flush), 32'd1);

        // Asynchronous reset while requesting
        wait_req(ok);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(rd_req), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_addr", 32'(rd_addr), 32'd0);
        tick();
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            tick();
            if (busy !== 1'b0 || rd_req !== 1'b0) bad++;
        end
        chk("post_rst_idle_cycles", 32'(bad), 32'd0);
        pulse_frame();
        chk("post_rst_flush", 32'(fifo_flush), 32'd1);

        // Bank selection from wr_frame_done
        do_reset();
        wr_frame_done = 1'b1;
        tick();
        wr_frame_done = 1'b0;
        pulse_frame();
        exp_q.push_back(PP_BASE);
        serve_burst();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("bank_second_flush", 32'(fifo_flush), 32'd1);
        exp_q.push_back(PP_BASE);
        serve_burst();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
